// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add WIDTHxWIDTH multiplier sequenced on the shared 16-bit ALU
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic             Ready,
   output logic             Done,
   output logic [15:0]      Product,
   output logic [4:0]       AluFunSel,
   output logic [15:0]      AluA,
   output logic [15:0]      AluB,
   output logic             AluWF,
   input  logic [15:0]      AluOut
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [4:0] FS_PASS = 5'b10000;
   localparam logic [4:0] FS_ADD  = 5'b10100;
   localparam logic [4:0] FS_LSL  = 5'b11011;
   localparam logic [4:0] FS_LSR  = 5'b11100;

   typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHL, S_SHR, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [15:0]      mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [15:0]      prod_q, prod_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [15:0]      product_q, product_d;
   logic             last_iter;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         prod_q    <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         prod_q    <= prod_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   // ALU drive depends only on state and registers; AluOut is only ever captured.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      Ready     = 1'b0;
      Done      = 1'b0;
      AluFunSel = FS_PASS;
      AluA      = '0;
      AluB      = '0;
      AluWF     = 1'b0;
      last_iter = 1'b0;
      case (state_q)
         S_IDLE: begin
            Ready = 1'b1;
            if (Start) begin
               mcand_d  = 16'(OpA);
               mplier_d = OpB;
               prod_d   = '0;
               cnt_d    = '0;
               state_d  = S_ADD;
            end
         end
         S_ADD: begin
            AluA = prod_q;
            if (mplier_q[0]) begin
               AluFunSel = FS_ADD;
               AluB      = mcand_q;
               AluWF     = 1'b1;
               prod_d    = AluOut;
            end
            state_d = S_SHL;
         end
         S_SHL: begin
            AluFunSel = FS_LSL;
            AluA      = mcand_q;
            mcand_d   = AluOut;
            state_d   = S_SHR;
         end
         S_SHR: begin
            AluFunSel = FS_LSR;
            AluA      = 16'(mplier_q);
            mplier_d  = AluOut[WIDTH-1:0];
            last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef MUL_EARLY_EXIT_EN
            if (AluOut[WIDTH-1:0] == '0) last_iter = 1'b1;
`endif
            if (last_iter) begin
               product_d = prod_q;
               state_d   = S_DONE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = S_ADD;
            end
         end
         S_DONE: begin
            Done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign Product = product_q;

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that runs unsigned WIDTHxWIDTH multiplication on the shared 16-bit ArithmeticLogicUnit.
- Uses the shift-and-add method and issues only existing 16-bit FunSel codes: 10000 pass A, 10100 add, 11011 LSL, 11100 LSR.
- Sits between the control unit and the ALU operand/FunSel inputs. Owns the ALU while busy.
- Samples the combinational ALUOut in the same cycle it drives FunSel/A/B.

Parameters:
- WIDTH, 8, operand width. Legal range 1..8, so that 2*WIDTH <= 16.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; accepted only when Ready=1.
- OpA  in  WIDTH  multiplicand, sampled on the accepting edge.
- OpB  in  WIDTH  multiplier, sampled on the accepting edge.
- Ready  out  1  high only in IDLE.
- Done  out  1  one-cycle pulse; Product is valid from this cycle.
- Product  out  16  result; held until the next accepted Start.
- AluFunSel  out  5  to ALU FunSel.
- AluA  out  16  to ALU A.
- AluB  out  16  to ALU B.
- AluWF  out  1  to ALU WF; high only on performed adds.
- AluOut  in  16  from ALU ALUOut (combinational).

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE.
  - Mcand=0, Mplier=0, Prod=0, Cnt=0, Product=0.
  - Done=0, Ready=1.
  - AluFunSel=10000, AluA=0, AluB=0, AluWF=0.
  - Applies immediately, including mid-operation. The partial result is discarded and Done is not produced.
- Internal registers:
  - Mcand: 16 bits.
  - Mplier: WIDTH bits.
  - Prod: 16 bits.
  - Cnt: counts 0..WIDTH-1.
- IDLE:
  - Outputs: Ready=1, FunSel=10000, A=B=0, WF=0.
  - On Start=1 at a rising edge: Mcand<={zero-extend OpA}, Mplier<=OpB, Prod<=0, Cnt<=0, then go to ADD.
- ADD:
  - If Mplier[0]=1: FunSel=10100, A=Prod, B=Mcand, WF=1, Prod<=AluOut.
  - Else: FunSel=10000, A=Prod, B=0, WF=0, Prod unchanged.
  - Next state: SHL.
- SHL:
  - FunSel=11011, A=Mcand, B=0, WF=0.
  - Mcand<=AluOut.
  - Next state: SHR.
- SHR:
  - FunSel=11100, A={zero-pad, Mplier}, B=0, WF=0.
  - Mplier<=AluOut[WIDTH-1:0].
  - If Cnt==WIDTH-1: go to DONE. Else Cnt<=Cnt+1 and go to ADD.
- DONE:
  - Product<=Prod is registered on the edge entering DONE, so it is valid while Done=1.
  - Done=1 for exactly one cycle. Ready=0. FunSel=10000, A=B=0, WF=0.
  - Next state: IDLE.
- Latency: the accepting edge is followed by 3*WIDTH busy cycles, then one Done cycle. For WIDTH=8, Done is high in cycle 25 after the accepting edge, and Ready returns in cycle 26.
- Start while Ready=0 (busy or DONE) is ignored and not queued. OpA/OpB changes while busy have no effect.
- Arithmetic: all values are unsigned. Prod never exceeds (2^WIDTH-1)^2 < 2^16, so ALU carry/overflow flags are never consulted.
- FunSel/A/B/WF are combinational functions of state and registers only. They are never derived from AluOut, so there is no combinational loop.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: in SHR, if AluOut[WIDTH-1:0]==0, go to DONE regardless of Cnt. Latency becomes 3*(index of highest set bit of OpB, 1-based) busy cycles; OpB=0 takes 3 busy cycles. Product is identical to the non-early-exit result.
- Undefined: fixed latency of 3*WIDTH busy cycles, as above.

Test Plan:
- Reset, then Start with OpA=13, OpB=11 (WIDTH=8) -> Product=0x008F, Done pulse exactly 1 cycle in cycle 25, Ready=1 in cycle 26.
- OpA=255, OpB=255 -> Product=0xFE01. AluWF high in exactly 8 cycles. Product holds 0xFE01 until the next accepted Start.
- OpA=7, OpB=0 -> Product=0x0000. AluWF never high. Done in cycle 25 without MUL_EARLY_EXIT_EN, in cycle 4 with it.
- Start re-asserted with OpA=1, OpB=1 during busy cycles 5..24 of a 13x11 run -> ignored; result 0x008F; next Start accepted only once Ready=1.
- Reset pulsed low in cycle 10 of a 255x255 run -> immediately Ready=1, Product=0, AluFunSel=10000, AluWF=0, no Done. A following 3x5 run gives 0x000F.
- With MUL_EARLY_EXIT_EN: OpA=200, OpB=0x03 -> Product=0x0258 (600), Done in cycle 7.
